// File: rtl/axi_adapter_pkg.sv
// Shared types and constants for the AXI read-to-stream adapter.
package axi_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rd_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned BOUNDARY_4K    = 4096;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with registered outputs; ready depends only on state.
module axis_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             out_vld_q, out_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             push;

    // Full means both entries hold data; the skid entry only fills behind a stalled output.
    assign in_ready_o  = !skid_vld_q;
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_dat_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || out_ready_i) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = push;
                if (push) out_dat_d = in_data_i;
            end
        end else if (push) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/axi_adapter_rd.sv
// AXI4 read master: splits a beat-count command into 4 KB-safe INCR bursts and streams the data out on AXIS.
module axi_adapter_rd
    import axi_adapter_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]               cmd_beats,
    output logic                      done,
    output logic                      rd_err,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int PW    = AXI_DATA_WIDTH + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    rd_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]               rem_q, rem_d;
    logic [8:0]                beat_q, beat_d;
    logic                      err_q, err_d;

    logic [16:0]   to_4k, len;
    logic          last_in_burst, cmd_last, r_hs, skid_rdy;
    logic [PW-1:0] skid_out;

    // Burst length is derived from addr_q/rem_q, which stay frozen through ADDR and DATA.
    always_comb begin
        to_4k = (17'(BOUNDARY_4K) - {5'd0, addr_q[11:0]}) >> SIZE;
        len   = {1'b0, rem_q};
        if (len > 17'(MAX_BURST_LEN)) len = 17'(MAX_BURST_LEN);
        if (len > to_4k)              len = to_4k;
    end

    assign last_in_burst = ({8'd0, beat_q} == (len - 17'd1));
    assign cmd_last      = last_in_burst && ({1'b0, rem_q} == len);
    assign r_hs          = m_axi_rvalid && m_axi_rready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~ALIGN_MASK;
                    rem_d   = cmd_beats;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = (cmd_beats == 16'd0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) state_d = DATA;
            end
            DATA: begin
                if (r_hs) begin
                    if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != last_in_burst) err_d = 1'b1;
                    if (last_in_burst) begin
                        beat_d  = '0;
                        addr_d  = addr_q + (AXI_ADDR_WIDTH'(len) << SIZE);
                        rem_d   = rem_q - len[15:0];
                        state_d = (rem_q == len[15:0]) ? DONE : ADDR;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign done          = (state_q == DONE);
    assign rd_err        = err_q;
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(len - 17'd1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = (state_q == DATA) && skid_rdy;

    axis_skid_buf #(.WIDTH(PW)) u_skid (
        .clk_i       (axi_aclk),
        .rst_ni      (axi_aresetn),
        .in_valid_i  ((state_q == DATA) && m_axi_rvalid),
        .in_ready_o  (skid_rdy),
        .in_data_i   ({m_axi_rdata, cmd_last}),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (skid_out)
    );

    assign m_axis_tdata = skid_out[PW-1:1];
    assign m_axis_tlast = skid_out[0];

endmodule

// File: tb/tb_axi_adapter_rd.sv
// Bench for axi_adapter_rd: AXI slave model, AXIS scoreboard, one task per scenario.
module tb_axi_adapter_rd;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, done, rd_err;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] tdata;
    logic        tlast, tvalid, tready;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    ar_t         ar_log[$];
    logic [32:0] exp_q[$];
    int cmp_cnt = 0, mis_cnt = 0;
    int done_cnt = 0, full_cnt = 0, r_total = 0;
    int err_at = -1;
    bit lat_mode = 0, tr_mode = 0;

    axi_adapter_rd dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .done(done), .rd_err(rd_err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // AXI slave: drives at negedge, samples the upcoming handshakes 1 time unit later.
    initial begin : slave
        bit ar_hs, r_hs, ar_pend;
        ar_t cap, prev;
        logic [31:0] b_addr;
        int bl, bk;
        ar_hs = 0; r_hs = 0; ar_pend = 0; bl = 0; bk = 0; b_addr = 0; cap = '0; prev = '0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bl = 0; ar_hs = 0; r_hs = 0; ar_pend = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
                continue;
            end
            if (ar_hs) begin
                ar_log.push_back(cap);
                b_addr = cap.addr; bl = int'(cap.len) + 1; bk = 0;
            end
            if (r_hs) begin
                bk++; bl--; r_total++;
            end
            arready = (bl == 0) && ar_pend;
            rvalid  = (bl > 0);
            rdata   = b_addr + 32'(bk * 4);
            rlast   = (bl == 1);
            rresp   = (bl > 0 && r_total == err_at) ? 2'b10 : 2'b00;
            #1;
            if (bl > 0) begin
                cmp_cnt++;
                if (arvalid !== 1'b0) begin
                    mis_cnt++; $display("FAIL ar_outstanding: arvalid=%b required 0 during burst", arvalid);
                end
            end
            if (ar_pend) begin
                cmp_cnt++;
                if (arvalid !== 1'b1 || araddr !== prev.addr || arlen !== prev.len) begin
                    mis_cnt++;
                    $display("FAIL ar_stable: got v=%b %h/%0d required 1 %h/%0d", arvalid, araddr, arlen, prev.addr, prev.len);
                end
            end
            cap     = '{addr: araddr, len: arlen, size: arsize, burst: arburst};
            ar_hs   = arvalid && arready;
            r_hs    = rvalid && rready;
            ar_pend = arvalid && !arready;
            prev    = cap;
        end
    end

    // AXIS sink: drives tready, pops the scoreboard, checks hold/latency/error timing.
    initial begin : monitor
        bit tog, p_tv, p_tr, p_tl, p_rhs, p_rerr;
        logic [31:0] p_td, p_rd;
        logic [32:0] e;
        tog = 0; p_tv = 0; p_tr = 0; p_tl = 0; p_rhs = 0; p_rerr = 0; p_td = 0; p_rd = 0;
        tready = 1;
        forever begin
            @(negedge clk);
            tog    = ~tog;
            tready = tr_mode ? tog : 1'b1;
            #1;
            if (!rst_n) begin
                exp_q.delete();
                p_tv = 0; p_rhs = 0; p_rerr = 0;
                continue;
            end
            if (done) done_cnt++;
            if (rvalid && !rready) full_cnt++;
            if (lat_mode && p_rhs) begin
                cmp_cnt++;
                if (tvalid !== 1'b1 || tdata !== p_rd) begin
                    mis_cnt++; $display("FAIL r2s_latency: got v=%b %h required 1 %h", tvalid, tdata, p_rd);
                end
            end
            if (p_tv && !p_tr) begin
                cmp_cnt++;
                if (tvalid !== 1'b1 || tdata !== p_td || tlast !== p_tl) begin
                    mis_cnt++;
                    $display("FAIL axis_hold: got v=%b %h/%b required 1 %h/%b", tvalid, tdata, tlast, p_td, p_tl);
                end
            end
            if (p_rerr) begin
                cmp_cnt++;
                if (rd_err !== 1'b1) begin
                    mis_cnt++; $display("FAIL rd_err_timing: got %b required 1", rd_err);
                end
            end
            if (tvalid && tready) begin
                cmp_cnt++;
                if (exp_q.size() == 0) begin
                    mis_cnt++; $display("FAIL axis_extra: got beat %h/%b required none", tdata, tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({tdata, tlast} !== e) begin
                        mis_cnt++; $display("FAIL axis_beat: got %h/%b required %h/%b", tdata, tlast, e[32:1], e[0]);
                    end
                end
            end
            p_tv = tvalid; p_tr = tready; p_td = tdata; p_tl = tlast;
            p_rhs = rvalid && rready; p_rd = rdata;
            p_rerr = rvalid && rready && (rresp != 2'b00);
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] n, output bit ok);
        logic [31:0] base;
        @(negedge clk);
        cmd_valid = 1; cmd_addr = a; cmd_beats = n;
        base = a & 32'hFFFF_FFFC;
        for (int i = 0; i < int'(n); i++) exp_q.push_back({base + 32'(i * 4), i == int'(n) - 1});
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int target, input string nm);
        int c;
        c = 0;
        while (done_cnt < target && c < 2000) begin @(negedge clk); c++; end
        while (exp_q.size() != 0 && c < 2000) begin @(negedge clk); c++; end
        repeat (4) @(negedge clk);
        cmp_cnt++;
        if (c >= 2000) begin
            mis_cnt++; $display("FAIL %s_timeout: done=%0d pending=%0d required done>=%0d pending=0", nm, done_cnt, exp_q.size(), target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        cmp_cnt++;
        if ({cmd_ready, done, rd_err, arvalid, rready, tvalid, tlast} !== 7'b1000000) begin
            mis_cnt++;
            $display("FAIL reset_outputs: got rdy/done/err/arv/rrdy/tv/tl=%b required 1000000",
                     {cmd_ready, done, rd_err, arvalid, rready, tvalid, tlast});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        #1;
        cmp_cnt++;
        if (cmd_ready !== 1'b1 || arvalid !== 1'b0 || tvalid !== 1'b0) begin
            mis_cnt++; $display("FAIL post_reset_idle: got rdy=%b arv=%b tv=%b required 1 0 0", cmd_ready, arvalid, tvalid);
        end
    endtask

    task automatic check_ars(input string nm, input ar_t exp[$]);
        cmp_cnt++;
        if (ar_log.size() != exp.size()) begin
            mis_cnt++; $display("FAIL %s_ar_count: got %0d required %0d", nm, ar_log.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                cmp_cnt++;
                if (ar_log[i] !== exp[i]) begin
                    mis_cnt++;
                    $display("FAIL %s_ar%0d: got %h/len%0d/sz%0d/b%0d required %h/len%0d/sz%0d/b%0d", nm, i,
                             ar_log[i].addr, ar_log[i].len, ar_log[i].size, ar_log[i].burst,
                             exp[i].addr, exp[i].len, exp[i].size, exp[i].burst);
                end
            end
        end
    endtask

    task automatic test_burst_split();
        int d0; bit ok; ar_t exp[$];
        ar_log.delete(); lat_mode = 1; tr_mode = 0; d0 = done_cnt;
        send_cmd(32'h1000, 16'd40, ok);
        cmp_cnt++;
        if (!ok) begin mis_cnt++; $display("FAIL split_cmd_accept: got 0 required 1"); end
        wait_idle(d0 + 1, "split");
        lat_mode = 0;
        cmp_cnt++;
        if (done_cnt - d0 != 1) begin mis_cnt++; $display("FAIL split_done: got %0d pulses required 1", done_cnt - d0); end
        exp = '{'{32'h1000, 8'd15, 3'd2, 2'b01}, '{32'h1040, 8'd15, 3'd2, 2'b01}, '{32'h1080, 8'd7, 3'd2, 2'b01}};
        check_ars("split", exp);
    endtask

    task automatic test_4k();
        int d0; bit ok; ar_t exp[$];
        ar_log.delete(); d0 = done_cnt;
        send_cmd(32'h0FF0, 16'd8, ok);
        wait_idle(d0 + 1, "4k");
        cmp_cnt++;
        if (!ok || exp_q.size() != 0) begin mis_cnt++; $display("FAIL 4k_beats: got ok=%b pending=%0d required 1 0", ok, exp_q.size()); end
        exp = '{'{32'h0FF0, 8'd3, 3'd2, 2'b01}, '{32'h1000, 8'd3, 3'd2, 2'b01}};
        check_ars("4k", exp);
    endtask

    task automatic test_zero_beats();
        int d0; bit ok;
        ar_log.delete(); d0 = done_cnt;
        send_cmd(32'h2000, 16'd0, ok);
        #1;
        cmp_cnt++;
        if (done !== 1'b1 || cmd_ready !== 1'b0) begin
            mis_cnt++; $display("FAIL zero_done: got done=%b rdy=%b required 1 0", done, cmd_ready);
        end
        @(negedge clk); #1;
        cmp_cnt++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            mis_cnt++; $display("FAIL zero_idle: got done=%b rdy=%b required 0 1", done, cmd_ready);
        end
        repeat (6) @(negedge clk);
        cmp_cnt++;
        if (ar_log.size() != 0 || done_cnt - d0 != 1) begin
            mis_cnt++; $display("FAIL zero_no_ar: got ars=%0d pulses=%0d required 0 1", ar_log.size(), done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int d0, f0; bit ok;
        d0 = done_cnt; f0 = full_cnt; tr_mode = 1;
        send_cmd(32'h3000, 16'd16, ok);
        wait_idle(d0 + 1, "bp");
        tr_mode = 0;
        cmp_cnt++;
        if (full_cnt == f0) begin mis_cnt++; $display("FAIL bp_rready_low: got 0 stalled cycles required >0"); end
        cmp_cnt++;
        if (!ok || done_cnt - d0 != 1) begin mis_cnt++; $display("FAIL bp_done: got ok=%b pulses=%0d required 1 1", ok, done_cnt - d0); end
    endtask

    task automatic test_error();
        int d0; bit ok;
        d0 = done_cnt; err_at = r_total + 2;
        send_cmd(32'h4000, 16'd8, ok);
        wait_idle(d0 + 1, "err");
        err_at = -1;
        cmp_cnt++;
        if (rd_err !== 1'b1) begin mis_cnt++; $display("FAIL err_sticky: got %b required 1", rd_err); end
        send_cmd(32'h4100, 16'd4, ok);
        #1;
        cmp_cnt++;
        if (rd_err !== 1'b0) begin mis_cnt++; $display("FAIL err_clear: got %b required 0", rd_err); end
        wait_idle(d0 + 2, "err2");
        cmp_cnt++;
        if (rd_err !== 1'b0 || done_cnt - d0 != 2) begin
            mis_cnt++; $display("FAIL err_clean_cmd: got err=%b pulses=%0d required 0 2", rd_err, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, base, c; bit ok;
        d0 = done_cnt; base = r_total; err_at = r_total + 1;
        send_cmd(32'h5000, 16'd16, ok);
        c = 0;
        while (r_total < base + 4 && c < 500) begin @(negedge clk); #2; c++; end
        cmp_cnt++;
        if (c >= 500) begin mis_cnt++; $display("FAIL rmid_timeout: got %0d beats required 4", r_total - base); end
        cmp_cnt++;
        if (rd_err !== 1'b1) begin mis_cnt++; $display("FAIL rmid_err_pre: got %b required 1", rd_err); end
        rst_n = 0;
        #1;
        cmp_cnt++;
        if ({cmd_ready, done, rd_err, arvalid, rready, tvalid, tlast} !== 7'b1000000) begin
            mis_cnt++;
            $display("FAIL rmid_outputs: got rdy/done/err/arv/rrdy/tv/tl=%b required 1000000",
                     {cmd_ready, done, rd_err, arvalid, rready, tvalid, tlast});
        end
        err_at = -1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        #1;
        cmp_cnt++;
        if (tvalid !== 1'b0 || exp_q.size() != 0 || done_cnt != d0) begin
            mis_cnt++; $display("FAIL rmid_flush: got tv=%b pending=%0d pulses=%0d required 0 0 0", tvalid, exp_q.size(), done_cnt - d0);
        end
        send_cmd(32'h6000, 16'd20, ok);
        wait_idle(d0 + 1, "rmid");
        cmp_cnt++;
        if (!ok || done_cnt - d0 != 1 || rd_err !== 1'b0) begin
            mis_cnt++; $display("FAIL rmid_rerun: got ok=%b pulses=%0d err=%b required 1 1 0", ok, done_cnt - d0, rd_err);
        end
    endtask

    task automatic test_back_to_back();
        int d0; bit ok1, ok2; ar_t exp[$];
        ar_log.delete(); d0 = done_cnt;
        send_cmd(32'h7003, 16'd4, ok1);
        send_cmd(32'h7FF8, 16'd6, ok2);
        wait_idle(d0 + 2, "b2b");
        cmp_cnt++;
        if (!ok1 || !ok2 || done_cnt - d0 != 2) begin
            mis_cnt++; $display("FAIL b2b_done: got ok=%b%b pulses=%0d required 11 2", ok1, ok2, done_cnt - d0);
        end
        exp = '{'{32'h7000, 8'd3, 3'd2, 2'b01}, '{32'h7FF8, 8'd1, 3'd2, 2'b01}, '{32'h8000, 8'd3, 3'd2, 2'b01}};
        check_ars("b2b", exp);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_beats = 0;
        test_reset();
        test_burst_split();
        test_4k();
        test_zero_beats();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
